pong_score_controller: RTL and testbench

//  Sequences a Pong match: takes point pulses from the ball/collision logic and keeps both players' scores.

---
 rtl/pong_pkg.sv | 18 +
 rtl/point_arbiter.sv | 38 +++
 rtl/pong_score_controller.sv | 184 ++++++++++++++++++
 tb/tb_pong_score_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared encodings for the Pong score controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic PLAYER_L = 1'b0;
    localparam logic PLAYER_R = 1'b1;

    localparam int SCORE_W = 10;

endpackage

// File: rtl/point_arbiter.sv
// Two-input round-robin arbiter for point pulses; keeps the last-grant flop.
// Latency: grant is combinational; last-grant updates on the following edge.
// Backpressure: none; the losing pulse of a simultaneous pair is dropped.
module point_arbiter
    import pong_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_l,
    input  logic req_r,
    input  logic en,
    output logic grant_valid,
    output logic grant_id
);

    logic last_q;
    logic last_d;

    // Grant selection: a lone request wins outright, a tie goes to whoever lost last time.
    always_comb begin
        grant_valid = en & (req_l | req_r);
        grant_id    = req_r ? PLAYER_R : PLAYER_L;
        if (req_l && req_r) begin
            grant_id = ~last_q;
        end
        last_d = grant_valid ? grant_id : last_q;
    end

    // Last-grant register; starts at right so the first tie goes to left.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= PLAYER_R;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/pong_score_controller.sv
// Pong match sequencer: serve/play/over FSM, score keeping, alternating score display.
// Latency: a granted point shows in the score one edge later; display mux is combinational.
// Backpressure: none; point pulses outside PLAY are ignored. SCORE_BLINK_EN enables winner blink in OVER.
module pong_score_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_CYCLES = 50000000,
    parameter int DISP_CYCLES  = 100000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                point_left,
    input  logic                point_right,
    output logic [SCORE_W-1:0]  score_left,
    output logic [SCORE_W-1:0]  score_right,
    output logic [SCORE_W-1:0]  disp_score,
    output logic                disp_sel,
    output logic                disp_blank,
    output logic                ball_freeze,
    output logic                serve_dir,
    output logic                game_over,
    output logic                winner
);

    localparam logic [31:0]        SERVE_LOAD = 32'(SERVE_CYCLES - 1);
    localparam logic [31:0]        DISP_LAST  = 32'(DISP_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    state_t             state_q, state_d;
    logic [31:0]        timer_q, timer_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic               serve_dir_q, serve_dir_d;
    logic               winner_q, winner_d;
    logic [31:0]        disp_cnt_q, disp_cnt_d;
    logic               disp_sel_q, disp_sel_d;
    logic               grant_valid;
    logic               grant_id;
    logic               disp_wrap;
    logic               enter_over;
    logic               leave_over;
    logic [SCORE_W-1:0] new_score;

    point_arbiter u_point_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req_l       (point_left),
        .req_r       (point_right),
        .en          (state_q == PLAY),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Match FSM next-state, serve timer and score updates.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        new_score   = (grant_id == PLAYER_R) ? (score_r_q + 1'b1) : (score_l_q + 1'b1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SERVE;
                    timer_d = SERVE_LOAD;
                end
            end
            SERVE: begin
                if (timer_q == 32'd0) begin
                    state_d = PLAY;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            PLAY: begin
                if (grant_valid) begin
                    if (grant_id == PLAYER_R) begin
                        score_r_d = new_score;
                    end else begin
                        score_l_d = new_score;
                    end
                    serve_dir_d = ~grant_id;
                    if (new_score == WIN_VAL) begin
                        state_d  = OVER;
                        winner_d = grant_id;
                    end else begin
                        state_d = SERVE;
                        timer_d = SERVE_LOAD;
                    end
                end
            end
            OVER: begin
                if (start) begin
                    state_d   = SERVE;
                    timer_d   = SERVE_LOAD;
                    score_l_d = '0;
                    score_r_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Display alternation: free-running wrap counter; frozen on the winner while in OVER.
    always_comb begin
        disp_wrap  = (disp_cnt_q == DISP_LAST);
        enter_over = (state_q != OVER) && (state_d == OVER);
        leave_over = (state_q == OVER) && (state_d != OVER);
        disp_cnt_d = disp_wrap ? 32'd0 : (disp_cnt_q + 32'd1);
        disp_sel_d = disp_sel_q;
        if (enter_over) begin
            disp_sel_d = winner_d;
        end else if ((state_q != OVER) && disp_wrap) begin
            disp_sel_d = ~disp_sel_q;
        end
        if (leave_over) begin
            disp_cnt_d = 32'd0;
        end
    end

    // Main state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            timer_q     <= 32'd0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            serve_dir_q <= PLAYER_L;
            winner_q    <= PLAYER_L;
            disp_cnt_q  <= 32'd0;
            disp_sel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            serve_dir_q <= serve_dir_d;
            winner_q    <= winner_d;
            disp_cnt_q  <= disp_cnt_d;
            disp_sel_q  <= disp_sel_d;
        end
    end

`ifdef SCORE_BLINK_EN
    logic disp_blank_q, disp_blank_d;

    // Winner blink: toggle on each display wrap while in OVER, cleared when the match restarts.
    always_comb begin
        disp_blank_d = disp_blank_q;
        if (leave_over) begin
            disp_blank_d = 1'b0;
        end else if ((state_q == OVER) && disp_wrap) begin
            disp_blank_d = ~disp_blank_q;
        end
    end

    // Blink register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_blank_q <= 1'b0;
        end else begin
            disp_blank_q <= disp_blank_d;
        end
    end

    assign disp_blank = disp_blank_q;
`else
    assign disp_blank = 1'b0;
`endif

    assign score_left  = score_l_q;
    assign score_right = score_r_q;
    assign disp_sel    = disp_sel_q;
    assign disp_score  = disp_sel_q ? score_r_q : score_l_q;
    assign ball_freeze = (state_q != PLAY);
    assign serve_dir   = serve_dir_q;
    assign game_over   = (state_q == OVER);
    assign winner      = winner_q;

endmodule

// File: tb/tb_pong_score_controller.sv
// Scoreboard bench for pong_score_controller with small timing parameters.
// Score/game-over changes are checked by a monitor against a queue of expected results.
// Timing, display and reset behaviour are checked inline by the stimulus process.
module tb_pong_score_controller;

    localparam int WIN = 3;
    localparam int SRV = 5;
    localparam int DSP = 4;

    typedef struct {
        logic [9:0] l;
        logic [9:0] r;
        logic       sd;
        logic       go;
        logic       win;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       point_left;
    logic       point_right;
    logic [9:0] score_left;
    logic [9:0] score_right;
    logic [9:0] disp_score;
    logic       disp_sel;
    logic       disp_blank;
    logic       ball_freeze;
    logic       serve_dir;
    logic       game_over;
    logic       winner;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    logic mon_en = 1'b0;

    pong_score_controller #(
        .WIN_SCORE    (WIN),
        .SERVE_CYCLES (SRV),
        .DISP_CYCLES  (DSP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .point_left  (point_left),
        .point_right (point_right),
        .score_left  (score_left),
        .score_right (score_right),
        .disp_score  (disp_score),
        .disp_sel    (disp_sel),
        .disp_blank  (disp_blank),
        .ball_freeze (ball_freeze),
        .serve_dir   (serve_dir),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input logic [9:0] l, input logic [9:0] r, input logic sd,
                        input logic go, input logic win);
        exp_t e;
        e.l = l; e.r = r; e.sd = sd; e.go = go; e.win = win;
        exp_q.push_back(e);
    endtask

    // Leaves the caller at a falling edge with the DUT in PLAY.
    task automatic wait_play();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!ball_freeze) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL wait_play: ball_freeze still 1 after 50 cycles, expected 0");
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // One rally ending with the given pulses; expected outcome queued for the monitor.
    task automatic rally(input logic l, input logic r, input logic [9:0] el, input logic [9:0] er,
                         input logic sd, input logic go, input logic win);
        wait_play();
        point_left  = l;
        point_right = r;
        push(el, er, sd, go, win);
        @(posedge clk); #1;
        point_left  = 1'b0;
        point_right = 1'b0;
        @(negedge clk);
        check("freeze_after_point", ball_freeze, 1);
    endtask

    // Monitor: every change of the score/game-over outputs consumes one expected entry.
    initial begin : monitor
        logic [9:0] pl, pr;
        logic       pg;
        exp_t       e;
        wait (mon_en);
        pl = score_left; pr = score_right; pg = game_over;
        forever begin
            @(negedge clk);
            if (score_left !== pl || score_right !== pr || game_over !== pg) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event: got L=%0d R=%0d go=%0d, expected no change",
                             score_left, score_right, game_over);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_score_left", score_left, e.l);
                    check("sb_score_right", score_right, e.r);
                    check("sb_serve_dir", serve_dir, e.sd);
                    check("sb_game_over", game_over, e.go);
                    if (e.go) check("sb_winner", winner, e.win);
                end
            end
            pl = score_left; pr = score_right; pg = game_over;
        end
    end

    initial begin : stim
        int cnt;
        int tog;
        logic prev;
        rst = 1'b0; start = 1'b0; point_left = 1'b0; point_right = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_score_left", score_left, 0);
        check("rst_score_right", score_right, 0);
        check("rst_ball_freeze", ball_freeze, 1);
        check("rst_game_over", game_over, 0);
        check("rst_winner", winner, 0);
        check("rst_disp_sel", disp_sel, 0);
        check("rst_disp_blank", disp_blank, 0);
        check("rst_serve_dir", serve_dir, 0);
        rst = 1'b1;
        mon_en = 1'b1;

        // Freeze length after start.
        pulse_start();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ball_freeze) break;
            cnt++;
        end
        check("serve_freeze_cycles", cnt, SRV);

        // Tie with last grant = right -> left; point during SERVE ignored.
        rally(1'b1, 1'b1, 10'd1, 10'd0, 1'b1, 1'b0, 1'b0);
        point_right = 1'b1;
        @(posedge clk); #1 point_right = 1'b0;
        @(negedge clk);
        check("serve_ignore_left", score_left, 1);
        check("serve_ignore_right", score_right, 0);
        // Tie again -> right this time.
        rally(1'b1, 1'b1, 10'd1, 10'd1, 1'b0, 1'b0, 1'b0);
        // Single left point.
        rally(1'b1, 1'b0, 10'd2, 10'd1, 1'b1, 1'b0, 1'b0);

        // Reset mid-PLAY at 2:1, with a point pulse in the reset cycle.
        wait_play();
        rst = 1'b0;
        point_left = 1'b1;
        push(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        point_left = 1'b0;
        @(negedge clk);
        check("midrst_freeze", ball_freeze, 1);
        check("midrst_disp_sel", disp_sel, 0);

        // Right wins 3:0.
        pulse_start();
        rally(1'b0, 1'b1, 10'd0, 10'd1, 1'b0, 1'b0, 1'b0);
        rally(1'b0, 1'b1, 10'd0, 10'd2, 1'b0, 1'b0, 1'b0);
        rally(1'b0, 1'b1, 10'd0, 10'd3, 1'b0, 1'b1, 1'b1);
        check("over_game_over", game_over, 1);
        check("over_winner", winner, 1);
        check("over_disp_sel", disp_sel, 1);
        check("over_disp_score", disp_score, 3);

        // Points in OVER are ignored.
        point_left = 1'b1;
        @(posedge clk); #1 point_left = 1'b0;
        @(negedge clk);
        check("over_ignore_left", score_left, 0);
        check("over_ignore_right", score_right, 3);

        // In OVER: selection frozen, blank toggles per wrap only with the blink build.
        tog = 0;
        cnt = 0;
        prev = disp_blank;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (disp_blank !== prev) tog++;
            if (disp_sel !== 1'b1) cnt++;
            prev = disp_blank;
        end
        check("over_sel_changes", cnt, 0);
`ifdef SCORE_BLINK_EN
        check("over_blank_toggles", tog, 4);
`else
        check("over_blank_toggles", tog, 0);
`endif

        // Restart from OVER clears scores.
        push(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        @(negedge clk);
        check("restart_blank", disp_blank, 0);
        check("restart_game_over", game_over, 0);

        // Outside OVER the selection toggles every DSP cycles.
        tog = 0;
        prev = disp_sel;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (disp_sel !== prev) tog++;
            prev = disp_sel;
        end
        check("run_sel_toggles", tog, 16 / DSP);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
